gemm_c_writeback: RTL and testbench
===================================

Name: gemm_c_writeback

Overview:
- Downstream stage of the GeMM accelerator top.
- Captures each full M×N output tile (OutDataWidth per element) when the accelerator strobes its C write-enable, and buffers it in a small tile FIFO.
- Drains each tile to a narrower output SRAM port, BeatElems elements per beat, under a request/grant handshake.
- Decouples the accelerator's single-cycle result pulse from a backpressured memory.

Parameters:
OutDataWidth, 32, width of one C element
M, 4, tile rows
N, 4, tile columns
AddrWidthC, 10, width of incoming tile index
BeatElems, 4, elements per memory beat; must divide M*N
MemAddrWidth, 12, output SRAM address width; must be ≥ AddrWidthC + clog2(M*N/BeatElems)
FifoDepth, 2, tile FIFO entries (≥1)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
tile_valid_i  input  1  tile present this cycle (driven by accelerator C write-enable)
tile_addr_i  input  AddrWidthC  tile index (accelerator C address)
tile_data_i  input  OutDataWidth*M*N  tile; element e=m*N+n at bits [e*OutDataWidth +: OutDataWidth]
tile_ready_o  output  1  FIFO can accept a tile this cycle
mem_req_o  output  1  write beat valid
mem_addr_o  output  MemAddrWidth  beat address
mem_wdata_o  output  OutDataWidth*BeatElems  beat data
mem_gnt_i  input  1  memory accepts beat this cycle
idle_o  output  1  FIFO empty and no beat pending
overflow_o  output  1  sticky: tile dropped because FIFO full
tiles_done_o  output  16  count of fully written tiles, wraps at 2^16

Behaviour:
- Reset (asynchronous, rst_ni low): FIFO empty, beat counter 0, tiles_done_o=0, overflow_o=0.
  - Outputs during and after reset: tile_ready_o=1, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, idle_o=1.
  - Reset mid-drain discards all buffered tiles; no further beats are issued.
- NumBeats = M*N/BeatElems.
- tile_ready_o = (occupancy < FifoDepth). It depends on registered occupancy only, with no combinational path from mem_gnt_i.
- Push: tile_valid_i && tile_ready_o stores {tile_addr_i, tile_data_i} at tail. Occupancy increments next cycle unless a pop occurs in the same cycle.
- Drop: tile_valid_i && !tile_ready_o discards the tile and sets overflow_o=1 on the next edge. overflow_o stays 1 until reset.
- Drain (head entry, beat counter b):
  - mem_req_o = occupancy != 0, driven from registers.
  - mem_addr_o = head_addr*NumBeats + b, zero-extended to MemAddrWidth.
  - mem_wdata_o = head elements b*BeatElems .. b*BeatElems+BeatElems-1, with element b*BeatElems in the LSBs.
  - mem_req_o && mem_gnt_i: if b < NumBeats-1 then b++. Otherwise b←0, pop head, and tiles_done_o++.
  - mem_req_o && !mem_gnt_i: mem_addr_o and mem_wdata_o hold stable. The request may not be withdrawn.
  - mem_gnt_i while mem_req_o=0 is ignored.
- Simultaneous push and final-beat pop in one cycle: both occur and occupancy is unchanged. With FifoDepth full, tile_ready_o is still 0 that cycle, so the incoming tile is dropped.
- Throughput: one beat per cycle with continuous grant. The first beat of a tile pushed into an empty FIFO appears the cycle after the push.
- When mem_req_o=0, mem_addr_o and mem_wdata_o are 0.
- idle_o = (occupancy == 0).
- Address arithmetic is modulo 2^MemAddrWidth; no saturation.

Test Plan:
- Reset then a single tile, data elements e=0..15 with value 100+e, tile_addr_i=3, mem_gnt_i always 1 → 4 beats on consecutive cycles, addresses 12,13,14,15. Beat 0 wdata = {103,102,101,100} (100 in LSBs). tiles_done_o=1, idle_o=1 afterwards.
- Same tile with mem_gnt_i=1 only every 3rd cycle → each beat's addr/data stable while ungranted, same 4 beats in order, no loss.
- Two tiles on back-to-back cycles (addrs 0 and 1), mem_gnt_i=0 → both accepted and tile_ready_o=0 after the second. Then grant continuously → addresses 0..3 then 4..7, tiles_done_o=2.
- FIFO full with mem_gnt_i=0, third tile_valid_i pulse → overflow_o=1 and stays 1. The third tile is never written; only 8 beats are issued.
- Assert rst_ni low after beat 1 of a tile → mem_req_o=0 immediately, and all outputs at their reset values. After release, no further beats and tiles_done_o=0.
- Push on the same cycle as the final-beat grant with occupancy 1 → the new tile drains next with no gap cycle. Occupancy stays 1 across that edge.

Source files
------------

// File: rtl/gemm_c_writeback_if.sv
// rtl/gemm_c_writeback_if.sv - tile capture and output SRAM beat handshake signals
interface gemm_c_writeback_if #(
    parameter int OutDataWidth = 32,
    parameter int M            = 4,
    parameter int N            = 4,
    parameter int AddrWidthC   = 10,
    parameter int BeatElems    = 4,
    parameter int MemAddrWidth = 12
);
    logic                               tile_valid_i;
    logic [AddrWidthC-1:0]              tile_addr_i;
    logic [OutDataWidth*M*N-1:0]        tile_data_i;
    logic                               tile_ready_o;
    logic                               mem_req_o;
    logic [MemAddrWidth-1:0]            mem_addr_o;
    logic [OutDataWidth*BeatElems-1:0]  mem_wdata_o;
    logic                               mem_gnt_i;

    // Writeback block view
    modport slave (
        input  tile_valid_i, tile_addr_i, tile_data_i, mem_gnt_i,
        output tile_ready_o, mem_req_o, mem_addr_o, mem_wdata_o
    );

    // Accelerator / memory side view
    modport master (
        output tile_valid_i, tile_addr_i, tile_data_i, mem_gnt_i,
        input  tile_ready_o, mem_req_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/gemm_c_writeback.sv
// rtl/gemm_c_writeback.sv - buffers GeMM C tiles and drains them as SRAM write beats
module gemm_c_writeback #(
    parameter int OutDataWidth = 32,
    parameter int M            = 4,
    parameter int N            = 4,
    parameter int AddrWidthC   = 10,
    parameter int BeatElems    = 4,
    parameter int MemAddrWidth = 12,
    parameter int FifoDepth    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    gemm_c_writeback_if.slave bus,
    output logic        idle_o,
    output logic        overflow_o,
    output logic [15:0] tiles_done_o
);
    localparam int TileBits = OutDataWidth * M * N;
    localparam int BeatBits = OutDataWidth * BeatElems;
    localparam int NumBeats = (M * N) / BeatElems;
    localparam int BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam int PtrW     = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW     = $clog2(FifoDepth + 1);

    // Tile storage; contents need no reset because occupancy gates every read
    logic [AddrWidthC-1:0] r_addr_mem [FifoDepth];
    logic [TileBits-1:0]   r_data_mem [FifoDepth];

    logic [PtrW-1:0]  r_head;
    logic [PtrW-1:0]  r_tail;
    logic [CntW-1:0]  r_count;
    logic [BeatW-1:0] r_beat;
    logic             r_overflow;
    logic [15:0]      r_tiles_done;

    logic                    w_ready;
    logic                    w_req;
    logic                    w_push;
    logic                    w_grant;
    logic                    w_last;
    logic                    w_pop;
    logic [AddrWidthC-1:0]   w_head_addr;
    logic [TileBits-1:0]     w_head_data;
    logic [BeatBits-1:0]     w_beats [NumBeats];
    logic [MemAddrWidth-1:0] w_addr;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready and request come only from registered occupancy, never from the grant
    assign w_ready = (r_count < CntW'(FifoDepth));
    assign w_req   = (r_count != '0);
    assign w_push  = bus.tile_valid_i && w_ready;
    assign w_grant = w_req && bus.mem_gnt_i;
    assign w_last  = (r_beat == BeatW'(NumBeats - 1));
    assign w_pop   = w_grant && w_last;

    assign w_head_addr = r_addr_mem[r_head];
    assign w_head_data = r_data_mem[r_head];

    // Slice the head tile into beats, lowest element of each beat in the LSBs
    for (genvar g = 0; g < NumBeats; g++) begin : g_beat
        assign w_beats[g] = w_head_data[g*BeatBits +: BeatBits];
    end

    // Beat address wraps modulo the SRAM address space
    assign w_addr = MemAddrWidth'(w_head_addr) * MemAddrWidth'(NumBeats)
                  + MemAddrWidth'(r_beat);

    assign bus.tile_ready_o = w_ready;
    assign bus.mem_req_o    = w_req;
    assign bus.mem_addr_o   = w_req ? w_addr : '0;
    assign bus.mem_wdata_o  = w_req ? w_beats[r_beat] : '0;
    assign idle_o           = !w_req;
    assign overflow_o       = r_overflow;
    assign tiles_done_o     = r_tiles_done;

    // Write an accepted tile into the tail slot
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_addr_mem[r_tail] <= bus.tile_addr_i;
            r_data_mem[r_tail] <= bus.tile_data_i;
        end
    end

    // FIFO pointers and occupancy; push and final-beat pop may coincide
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Beat counter advances on each grant and wraps after the last beat of a tile
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_beat <= '0;
        end else if (w_grant) begin
            r_beat <= w_last ? '0 : r_beat + 1'b1;
        end
    end

    // Sticky drop flag and completed-tile counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow   <= 1'b0;
            r_tiles_done <= '0;
        end else begin
            if (bus.tile_valid_i && !w_ready) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_tiles_done <= r_tiles_done + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_gemm_c_writeback.sv
// tb/tb_gemm_c_writeback.sv - self-checking bench for gemm_c_writeback
module tb_gemm_c_writeback;
    localparam int W     = 32;
    localparam int M     = 4;
    localparam int N     = 4;
    localparam int AW    = 10;
    localparam int BE    = 4;
    localparam int MAW   = 12;
    localparam int DEPTH = 2;
    localparam int NB    = (M * N) / BE;
    localparam int TB    = W * M * N;
    localparam int BB    = W * BE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        idle;
    logic        ovf;
    logic [15:0] done;

    gemm_c_writeback_if #(.OutDataWidth(W), .M(M), .N(N), .AddrWidthC(AW),
                          .BeatElems(BE), .MemAddrWidth(MAW)) bus();

    gemm_c_writeback #(.OutDataWidth(W), .M(M), .N(N), .AddrWidthC(AW),
                       .BeatElems(BE), .MemAddrWidth(MAW), .FifoDepth(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
        .idle_o      (idle),
        .overflow_o  (ovf),
        .tiles_done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [TB-1:0] data;
    } tile_t;

    tile_t q[$];
    int    m_beat;
    int    m_done;
    bit    m_ovf;
    int    obs[$];
    int    n_checks;
    int    n_errors;

    typedef struct {
        logic           v;
        logic           g;
        logic           exp_req;
        logic [MAW-1:0] exp_addr;
        logic [BB-1:0]  exp_wdata;
        logic           exp_idle;
        logic [15:0]    exp_done;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [TB-1:0] mk_tile(input int base);
        logic [TB-1:0] t;
        for (int e = 0; e < M * N; e++) t[e*W +: W] = W'(base + e);
        return t;
    endfunction

    function automatic logic [TB-1:0] rnd_tile();
        logic [TB-1:0] t;
        for (int e = 0; e < M * N; e++) t[e*W +: W] = $urandom;
        return t;
    endfunction

    function automatic logic [BB-1:0] model_wdata();
        logic [BB-1:0] r;
        r = '0;
        if (q.size() != 0) begin
            for (int k = 0; k < BE; k++) r[k*W +: W] = q[0].data[(m_beat*BE + k)*W +: W];
        end
        return r;
    endfunction

    function automatic int model_addr();
        if (q.size() == 0) return 0;
        return (int'(q[0].addr) * NB + m_beat) % (1 << MAW);
    endfunction

    task automatic model_reset();
        q.delete();
        m_beat = 0;
        m_done = 0;
        m_ovf  = 0;
    endtask

    task automatic check_model();
        chk("ready", bus.tile_ready_o, q.size() < DEPTH);
        chk("req",   bus.mem_req_o,    q.size() != 0);
        chk("addr",  bus.mem_addr_o,   model_addr());
        chk("wdata", bus.mem_wdata_o,  model_wdata());
        chk("idle",  idle,             q.size() == 0);
        chk("ovf",   ovf,              m_ovf);
        chk("done",  done,             m_done);
    endtask

    // Drive one cycle of inputs, check against the model, then advance the model across the edge
    task automatic apply(input logic v, input logic [AW-1:0] a, input logic [TB-1:0] d, input logic g);
        bit rdy;
        bus.tile_valid_i = v;
        bus.tile_addr_i  = a;
        bus.tile_data_i  = d;
        bus.mem_gnt_i    = g;
        check_model();
        rdy = (q.size() < DEPTH);
        if (bus.mem_req_o && g) obs.push_back(int'(bus.mem_addr_o));
        @(posedge clk);
        if (q.size() != 0 && g) begin
            if (m_beat == NB - 1) begin
                q.delete(0);
                m_beat = 0;
                m_done = (m_done + 1) % 65536;
            end else begin
                m_beat++;
            end
        end
        if (v) begin
            if (rdy) q.push_back('{addr: a, data: d});
            else     m_ovf = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        bus.tile_valid_i = 1'b0;
        bus.mem_gnt_i    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_req",   bus.mem_req_o,    1'b0);
        chk("rst_addr",  bus.mem_addr_o,   '0);
        chk("rst_wdata", bus.mem_wdata_o,  '0);
        chk("rst_ready", bus.tile_ready_o, 1'b1);
        chk("rst_idle",  idle,             1'b1);
        chk("rst_ovf",   ovf,              1'b0);
        chk("rst_done",  done,             16'd0);
        model_reset();
        obs.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_obs(input string name, input int first, input int cnt);
        chk({name, "_n"}, obs.size(), cnt);
        for (int i = 0; i < cnt && i < obs.size(); i++) chk(name, obs[i], first + i);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.tile_valid_i = 1'b0;
        bus.tile_addr_i  = '0;
        bus.tile_data_i  = '0;
        bus.mem_gnt_i    = 1'b0;
        model_reset();

        tbl[0] = '{1'b1, 1'b1, 1'b0, 12'd0,  '0, 1'b1, 16'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 12'd12, {32'd103, 32'd102, 32'd101, 32'd100}, 1'b0, 16'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 12'd13, {32'd107, 32'd106, 32'd105, 32'd104}, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 12'd14, {32'd111, 32'd110, 32'd109, 32'd108}, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 12'd15, {32'd115, 32'd114, 32'd113, 32'd112}, 1'b0, 16'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 12'd0,  '0, 1'b1, 16'd1};

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single tile, continuous grant, against the fixed table
        for (int i = 0; i < 6; i++) begin
            chk("tbl_req",   bus.mem_req_o,   tbl[i].exp_req);
            chk("tbl_addr",  bus.mem_addr_o,  tbl[i].exp_addr);
            chk("tbl_wdata", bus.mem_wdata_o, tbl[i].exp_wdata);
            chk("tbl_idle",  idle,            tbl[i].exp_idle);
            chk("tbl_done",  done,            tbl[i].exp_done);
            apply(tbl[i].v, 10'd3, mk_tile(100), tbl[i].g);
        end

        // Same tile, grant every third cycle
        do_reset();
        apply(1'b1, 10'd3, mk_tile(100), 1'b0);
        for (int c = 0; c < 40 && q.size() != 0; c++) apply(1'b0, '0, '0, (c % 3) == 2);
        chk_obs("slow_addr", 12, 4);
        chk("slow_done", done, 16'd1);

        // Two tiles fill the FIFO, third is dropped, then drain
        do_reset();
        apply(1'b1, 10'd0, mk_tile(0), 1'b0);
        apply(1'b1, 10'd1, mk_tile(16), 1'b0);
        chk("full_ready", bus.tile_ready_o, 1'b0);
        apply(1'b1, 10'd2, mk_tile(32), 1'b0);
        chk("drop_ovf", ovf, 1'b1);
        for (int c = 0; c < 12; c++) apply(1'b0, '0, '0, 1'b1);
        chk_obs("full_addr", 0, 8);
        chk("full_done", done, 16'd2);
        chk("ovf_sticky", ovf, 1'b1);

        // Reset after the second beat of a tile
        do_reset();
        apply(1'b1, 10'd5, mk_tile(200), 1'b1);
        apply(1'b0, '0, '0, 1'b1);
        apply(1'b0, '0, '0, 1'b1);
        do_reset();
        for (int c = 0; c < 6; c++) apply(1'b0, '0, '0, 1'b1);
        chk("postrst_beats", obs.size(), 0);
        chk("postrst_done", done, 16'd0);

        // Push coinciding with the final-beat grant
        do_reset();
        apply(1'b1, 10'd7, mk_tile(300), 1'b1);
        apply(1'b0, '0, '0, 1'b1);
        apply(1'b0, '0, '0, 1'b1);
        apply(1'b0, '0, '0, 1'b1);
        apply(1'b1, 10'd8, mk_tile(400), 1'b1);
        chk("nogap_req",  bus.mem_req_o,  1'b1);
        chk("nogap_addr", bus.mem_addr_o, 12'd32);
        chk("nogap_idle", idle,           1'b0);
        for (int c = 0; c < 6; c++) apply(1'b0, '0, '0, 1'b1);
        chk_obs("nogap_seq", 28, 8);
        chk("nogap_done", done, 16'd2);

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 500; c++) begin
            apply($urandom_range(0, 3) == 0, AW'($urandom), rnd_tile(), $urandom_range(0, 1) == 1);
        end
        for (int c = 0; c < 20; c++) apply(1'b0, '0, '0, 1'b1);
        chk("rand_idle", idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
